// File: rtl/asip_pkg.sv
// asip_pkg: shared opcodes, select encodings, FSM state and opcode-class types for the stepper ASIP.
package asip_pkg;
    localparam int IW    = 8;
    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h4;
    localparam logic [OPC_W-1:0] OP_IN   = 4'h5;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'h6;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_CALL = 4'h9;
    localparam logic [OPC_W-1:0] OP_WAIT = 4'hA;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    localparam logic [1:0] WA_R0   = 2'd0;
    localparam logic [1:0] WA_RX   = 2'd1;
    localparam logic [1:0] WA_RY   = 2'd2;
    localparam logic [1:0] WA_LINK = 2'd3;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_IMM  = 2'd1;
    localparam logic [1:0] WD_IN   = 2'd2;
    localparam logic [1:0] WD_PC   = 2'd3;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LDI, C_IN, C_OUT, C_JZ, C_JMP, C_CALL, C_WAIT, C_HALT, C_ILL
    } op_class_t;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_IMM, S_WB, S_WAIT, S_HALT
    } state_t;
endpackage

// File: rtl/asip_opcode_decode.sv
// asip_opcode_decode: combinational opcode -> control class and ALU operation.
module asip_opcode_decode
    import asip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class,
    output logic [1:0]       alu_op
);
    always_comb begin
        case (opcode)
            OP_NOP:                 op_class = C_NOP;
            OP_MOV, OP_ADD, OP_SUB: op_class = C_ALU;
            OP_LDI:                 op_class = C_LDI;
            OP_IN:                  op_class = C_IN;
            OP_OUT:                 op_class = C_OUT;
            OP_JZ:                  op_class = C_JZ;
            OP_JMP:                 op_class = C_JMP;
            OP_CALL:                op_class = C_CALL;
            OP_WAIT:                op_class = C_WAIT;
            OP_HALT:                op_class = C_HALT;
            default:                op_class = C_ILL;
        endcase
        alu_op = opcode == OP_ADD ? ALU_ADD : opcode == OP_SUB ? ALU_SUB : ALU_PASS;
    end
endmodule

// File: rtl/asip_control_fsm.sv
// asip_control_fsm: multi-cycle FETCH/DECODE/EXEC/WB sequencer of the stepper ASIP.
// Strobes are decoded from the registered state and IR, and forced low while reset_n is asserted.
module asip_control_fsm
    import asip_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] instr,
    input  logic          zero_flag,
    input  logic          step_done,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          imm_load,
    output logic          reg_write,
    output logic [1:0]    wa_sel,
    output logic [1:0]    wd_sel,
    output logic [1:0]    alu_op,
    output logic          out_load,
    output logic          illegal,
    output logic          halted
);
    state_t        state;
    logic [IW-1:0] ir;
    logic          zf;
    op_class_t     op_class;
    logic [1:0]    dec_alu;
    logic          unused_fields;

    // rx/ry select fields are consumed by the datapath, not by the sequencer
    assign unused_fields = ^ir[IW-OPC_W-1:0];

    asip_opcode_decode u_dec (
        .opcode   (ir[IW-1 -: OPC_W]),
        .op_class (op_class),
        .alu_op   (dec_alu)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            ir    <= '0;
            zf    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instr;
                    state <= S_DECODE;
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    zf <= zero_flag;
                    case (op_class)
                        C_ALU, C_IN:                 state <= S_WB;
                        C_LDI, C_JZ, C_JMP, C_CALL:  state <= S_IMM;
                        C_WAIT:                      state <= S_WAIT;
                        C_HALT:                      state <= S_HALT;
                        default:                     state <= S_FETCH;
                    endcase
                end
                S_IMM:   state <= S_WB;
                S_WB:    state <= S_FETCH;
                // a step_done pulse seen before entering this state is deliberately dropped
                S_WAIT:  state <= step_done ? S_FETCH : S_WAIT;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_load   = reset_n && state == S_FETCH;
        pc_inc    = reset_n && (state == S_FETCH || state == S_IMM);
        imm_load  = reset_n && state == S_IMM;
        pc_load   = reset_n && state == S_WB &&
                    (op_class == C_JMP || op_class == C_CALL || (op_class == C_JZ && zf));
        reg_write = reset_n && state == S_WB && op_class inside {C_ALU, C_LDI, C_IN, C_CALL};
        wa_sel    = !reg_write ? WA_R0 : op_class == C_ALU ? WA_RX : op_class == C_IN ? WA_RY :
                    op_class == C_CALL ? WA_LINK : WA_R0;
        wd_sel    = !reg_write ? WD_ALU : op_class == C_LDI ? WD_IMM : op_class == C_IN ? WD_IN :
                    op_class == C_CALL ? WD_PC : WD_ALU;
        alu_op    = reset_n && op_class == C_ALU && (state == S_EXEC || state == S_WB) ? dec_alu : ALU_PASS;
        out_load  = reset_n && state == S_EXEC && op_class == C_OUT;
        illegal   = reset_n && state == S_EXEC && op_class == C_ILL;
        halted    = reset_n && state == S_HALT;
    end
endmodule

// File: tb/tb_asip_control_fsm.sv
// tb_asip_control_fsm: per-cycle strobe checks against a per-opcode timing table built from the ISA rules.
module tb_asip_control_fsm;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       zero_flag = 1'b0;
    logic       step_done = 1'b0;
    logic       ir_load, pc_inc, pc_load, imm_load, reg_write, out_load, illegal, halted;
    logic [1:0] wa_sel, wd_sel, alu_op;

    int checks = 0;
    int fails  = 0;

    logic [13:0] exp_q[$];
    bit          sd_q[$];

    localparam logic [13:0] IRL = 14'h2000, PCI = 14'h1000, PCL = 14'h0800, IMM = 14'h0400;
    localparam logic [13:0] RW  = 14'h0200, OUTL = 14'h0004, ILL = 14'h0002, HLT = 14'h0001;

    wire [13:0] obs = {ir_load, pc_inc, pc_load, imm_load, reg_write, wa_sel, wd_sel, alu_op,
                       out_load, illegal, halted};

    asip_control_fsm dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .zero_flag(zero_flag), .step_done(step_done),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .imm_load(imm_load),
        .reg_write(reg_write), .wa_sel(wa_sel), .wd_sel(wd_sel), .alu_op(alu_op),
        .out_load(out_load), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] wr(int wa, int wd);
        return RW | 14'(wa << 7) | 14'(wd << 5);
    endfunction

    function automatic logic [13:0] alu(int a);
        return 14'(a << 3);
    endfunction

    task automatic push(input logic [13:0] e, input bit sd);
        exp_q.push_back(e);
        sd_q.push_back(sd);
    endtask

    // Expected strobe trace of one instruction, cycle by cycle, starting at its FETCH.
    task automatic plan(input logic [7:0] ins, input bit zf, input int nwait);
        int op = int'(ins[7:4]);
        bit noise;
        exp_q.delete();
        sd_q.delete();
        noise = ($urandom_range(0, 3) == 0);
        push(IRL | PCI, noise);
        noise = ($urandom_range(0, 3) == 0);
        push('0, noise);
        noise = ($urandom_range(0, 3) == 0);
        push(op >= 1 && op <= 3 ? alu(op - 1) : op == 6 ? OUTL : (op >= 11 && op <= 14) ? ILL : '0, noise);
        case (op)
            1, 2, 3: push(wr(1, 0) | alu(op - 1), 1'b0);
            4: begin push(IMM | PCI, 1'b0); push(wr(0, 1), 1'b0); end
            5: push(wr(2, 2), 1'b0);
            7: begin push(IMM | PCI, 1'b0); push(zf ? PCL : '0, 1'b0); end
            8: begin push(IMM | PCI, 1'b0); push(PCL, 1'b0); end
            9: begin push(IMM | PCI, 1'b0); push(PCL | wr(3, 3), 1'b0); end
            10: begin
                for (int k = 0; k < nwait; k++) push('0, 1'b0);
                push('0, 1'b1);
            end
            15: for (int k = 0; k < nwait; k++) push(HLT, 1'b0);
            default: ;
        endcase
    endtask

    task automatic run(input string tag, input logic [7:0] ins, input bit zf, input int nwait, input int limit);
        plan(ins, zf, nwait);
        for (int i = 0; i < exp_q.size() && (limit < 0 || i < limit); i++) begin
            @(negedge clk);
            instr     = i == 0 ? ins : 8'($urandom);
            zero_flag = i == 2 ? zf : 1'($urandom_range(0, 1));
            step_done = sd_q[i];
            #1;
            checks++;
            assert (obs === exp_q[i]) else begin
                fails++;
                $error("FAIL %s instr=%h cycle %0d: observed %h expected %h", tag, ins, i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic hold_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset_n   = 1'b0;
            step_done = 1'b0;
            #1;
            checks++;
            assert (obs === 14'h0) else begin
                fails++;
                $error("FAIL %s cycle %0d: observed %h expected 0000", tag, i, obs);
            end
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ins;
        int op;
        hold_reset("reset_init");
        run("add", 8'h27, 1'b0, 0, -1);
        run("ldi", 8'h40, 1'b0, 0, -1);
        run("jz_nt", 8'h70, 1'b0, 0, -1);
        run("jz_t", 8'h70, 1'b1, 0, -1);
        run("jmp", 8'h80, 1'b1, 0, -1);
        run("call", 8'h90, 1'b0, 0, -1);
        run("wait", 8'hA0, 1'b0, 20, -1);
        run("wait0", 8'hA0, 1'b0, 0, -1);
        run("out", 8'h64, 1'b0, 0, -1);
        run("in", 8'h53, 1'b0, 0, -1);
        run("mov", 8'h1B, 1'b0, 0, -1);
        run("sub", 8'h3E, 1'b1, 0, -1);
        run("nop", 8'h00, 1'b0, 0, -1);
        run("illegal", 8'hC0, 1'b0, 0, -1);
        run("abort_add", 8'h27, 1'b0, 0, 3);
        hold_reset("reset_mid");
        run("after_reset", 8'h27, 1'b0, 0, -1);
        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 14);
            ins = {4'(op), 4'($urandom)};
            run("random", ins, 1'($urandom_range(0, 1)), $urandom_range(0, 5), -1);
        end
        run("halt", 8'hF0, 1'b0, 100, -1);
        hold_reset("reset_halt");
        run("post_halt", 8'h4C, 1'b0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
